lvds_rx_frame_align: RTL
========================

# lvds_rx_frame_align

Receive-side word aligner for one deserialized LVDS lane, clocked on `rx_slowclk`. The block is the counterpart of the transmit-side training source. The far end sends a fixed training word. On a `start` pulse, this block sweeps the 8 possible bit offsets across two consecutive received words until the training word is seen repeatedly. It then locks that offset and delivers aligned words to the downstream PRBS checker, raising `fa_lock` as the frame-alignment status consumed by the top level.

## Interface
Parameters:
- `TRAIN_WORD`, 8'h0F: training word. All 8 of its rotations must be distinct.
- `SETTLE_CYC`, 4: cycles discarded after every offset change.
- `MATCH_CNT`, 16: consecutive matches required to lock (range 1..255).
- `CHECK_CYC`, 64: maximum compare cycles per offset. Must be > `MATCH_CNT`.
- `MAX_SWEEPS`, 2: full 8-offset sweeps allowed before failure (range 1..15).

Ports:
- `rx_slowclk`, in, 1: the single clock. All logic is on its rising edge.
- `rstn`, in, 1: reset. Synchronous, active-low.
- `rxpll_locked`, in, 1: RX PLL lock. Low means alignment is invalid.
- `start`, in, 1: single-cycle pulse that begins or restarts alignment.
- `data_in`, in, 8: raw deserialized word, one per cycle.
- `data_out`, out, 8: aligned word, registered.
- `data_valid`, out, 1: `data_out` is aligned; equals `fa_lock`.
- `fa_lock`, out, 1: alignment achieved.
- `fa_fail`, out, 1: sweep budget exhausted without lock.
- `busy`, out, 1: high while in SETTLE or CHECK.
- `offset`, out, 3: current or locked bit offset.

## Operation
- Window: `prev` register holds the previous `data_in`. `win = {data_in, prev}` (16 bits). `aligned = win[offset +: 8]`. `data_out <= aligned` every cycle, in every state.
- States: IDLE, SETTLE, CHECK, LOCKED, FAIL.
- IDLE: counters are 0. `start` with `rxpll_locked`=1 moves to SETTLE with `offset`=0 and `sweep`=0.
- SETTLE: counts `SETTLE_CYC` cycles, then moves to CHECK with `match`=0 and `chk`=0.
- CHECK: each cycle `chk` increments.
  - If `aligned`==`TRAIN_WORD`, `match` increments. Otherwise `match` returns to 0.
  - When a match brings `match` to `MATCH_CNT`, go to LOCKED. This has priority over a timeout on the same cycle.
  - Otherwise, when `chk` reaches `CHECK_CYC`-1: `offset` advances by 1 (7 wraps to 0). On the wrap, `sweep` increments. If `sweep` would reach `MAX_SWEEPS`, go to FAIL. Otherwise go to SETTLE.
- LOCKED: `fa_lock`=1 and `offset` is frozen. The state persists until `start`, `rxpll_locked`=0, or reset. There is no in-lock monitoring, because the payload is PRBS.
- FAIL: `fa_fail`=1 and `offset` holds 7. The state persists until `start` or reset.
- `start` in any state other than IDLE: restart at SETTLE with `offset`=0 and `sweep`=0. `fa_lock` and `fa_fail` clear on the next cycle.
- `rxpll_locked`=0 in any state: go to IDLE and clear `fa_lock`, `fa_fail` and `offset`. This takes priority over `start` on the same cycle.
- Counter widths:
  - `match` is 8 bits.
  - `chk` is sized by $clog2(`CHECK_CYC`).
  - `sweep` is 4 bits.
  - `settle` is sized by $clog2(`SETTLE_CYC`+1).
  - All counters saturate or clear as described above and never wrap silently.

## Timing
- Reset values (cycle after `rstn` low at an edge): state IDLE, `data_out`=0, `prev`=0, `fa_lock`=0, `data_valid`=0, `fa_fail`=0, `busy`=0, `offset`=0.
- `data_out` latency: 1 cycle from `data_in` (plus the `prev` stage for low offsets).
- `start` at edge t: `busy`=1 from t+1. The first compare is at cycle t+1+`SETTLE_CYC`.
- Best-case lock: `fa_lock` rises `SETTLE_CYC`+`MATCH_CNT` cycles after `busy` rises.
- Worst-case fail: `fa_fail` rises at `8*MAX_SWEEPS*(SETTLE_CYC+CHECK_CYC)` cycles after `start`.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package `lvds_align_pkg`:
  - State enum.
  - Default constants: `TRAIN_WORD`, `SETTLE_CYC`, `MATCH_CNT`, `CHECK_CYC`, `MAX_SWEEPS`.
  - A function that checks the rotation uniqueness of `TRAIN_WORD`, used by an elaboration-time assertion.
- One sub-module, `lvds_bit_shifter`: `prev` register, 16-bit window and registered 8-bit select by `offset`. Reused per lane.
- The top level instantiates one `lvds_rx_frame_align` per lane. It ANDs the per-lane `fa_lock` outputs into its `fa_lock` and drives `start` from its existing start pulse.

## Test plan
- Reset: hold `rstn`=0 with `data_in`=8'hFF for 3 cycles. Required: all outputs 0 and state IDLE.
- Lock at offset 3: feed a stream of 8'h0F rotated so that `win[3+:8]`=8'h0F, with `rxpll_locked`=1, then pulse `start`. Required: `offset` steps 0→1→2→3 and `fa_lock`=1 with `offset`=3. The lock cycle count equals 3*(4+64)+4+16. Afterwards `data_out`=8'h0F constantly.
- Interrupted matches: at the correct offset, inject one corrupted word after 15 matches. Required: `match` resets and lock is delayed by exactly 16 cycles. No offset advance occurs, since 32 < 64.
- Fail: `data_in`=8'h55 constantly, then `start`. Required: `fa_fail`=1 at cycle 2*8*68 and `fa_lock`=0 throughout.
- PLL drop: while LOCKED, drive `rxpll_locked`=0 for 1 cycle. Required: the next cycle shows `fa_lock`=0, state IDLE and `offset`=0. A `start` pulse on the same cycle is ignored.
- Restart: pulse `start` while in CHECK at offset 5. Required: `offset`=0, `sweep`=0 and `busy`=1 on the next cycle, and `fa_fail` does not assert.

Source files
------------

// File: rtl/lvds_align_pkg.sv
// Shared types and defaults for the LVDS receive-side word aligner.
package lvds_align_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_LOCKED,
        S_FAIL
    } align_state_e;

    localparam logic [7:0] DEF_TRAIN_WORD = 8'h0F;
    localparam int         DEF_SETTLE_CYC = 4;
    localparam int         DEF_MATCH_CNT  = 16;
    localparam int         DEF_CHECK_CYC  = 64;
    localparam int         DEF_MAX_SWEEPS = 2;

    // Two rotations coincide only if some nonzero rotation maps the word onto itself.
    function automatic logic rotations_unique(input logic [7:0] w);
        logic       ok;
        logic [7:0] r;
        ok = 1'b1;
        for (int k = 1; k < 8; k++) begin
            r = (w << k) | (w >> (8 - k));
            if (r == w) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lvds_bit_shifter.sv
// Two-word window over the deserialized lane and registered 8-bit select by bit offset.
module lvds_bit_shifter (
    input  logic       rx_slowclk,
    input  logic       rstn,
    input  logic [7:0] data_in,
    input  logic [2:0] offset,
    output logic [7:0] aligned,
    output logic [7:0] data_out
);

    logic [7:0]  prev_q, prev_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [15:0] win;

    always_comb begin
        win        = {data_in, prev_q};
        aligned    = win[offset +: 8];
        prev_d     = data_in;
        data_out_d = aligned;
    end

    always_ff @(posedge rx_slowclk) begin
        if (!rstn) begin
            prev_q     <= '0;
            data_out_q <= '0;
        end else begin
            prev_q     <= prev_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/lvds_rx_frame_align.sv
// Per-lane frame aligner: sweeps bit offsets until the training word repeats, then locks.
// state    | meaning
// S_IDLE   | waiting for start with RX PLL locked
// S_SETTLE | discarding words after an offset change
// S_CHECK  | counting consecutive training-word matches at this offset
// S_LOCKED | offset frozen, aligned data valid
// S_FAIL   | sweep budget exhausted, offset parked at 7
module lvds_rx_frame_align
    import lvds_align_pkg::*;
#(
    parameter logic [7:0] TRAIN_WORD = DEF_TRAIN_WORD,
    parameter int         SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int         MATCH_CNT  = DEF_MATCH_CNT,
    parameter int         CHECK_CYC  = DEF_CHECK_CYC,
    parameter int         MAX_SWEEPS = DEF_MAX_SWEEPS
) (
    input  logic       rx_slowclk,
    input  logic       rstn,
    input  logic       rxpll_locked,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       fa_lock,
    output logic       fa_fail,
    output logic       busy,
    output logic [2:0] offset
);

    localparam int CHK_W = $clog2(CHECK_CYC);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CHK_W-1:0] CHK_LAST  = CHK_W'(CHECK_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [7:0]       MATCH_TGT = 8'(MATCH_CNT);
    localparam logic [3:0]       SWEEP_MAX = 4'(MAX_SWEEPS);

    if (!rotations_unique(TRAIN_WORD)) begin : g_bad_train_word
        $error("TRAIN_WORD rotations are not all distinct");
    end
    if (CHECK_CYC <= MATCH_CNT || MATCH_CNT < 1 || MATCH_CNT > 255) begin : g_bad_match
        $error("MATCH_CNT must be 1..255 and below CHECK_CYC");
    end
    if (MAX_SWEEPS < 1 || MAX_SWEEPS > 15 || SETTLE_CYC < 1) begin : g_bad_sweep
        $error("MAX_SWEEPS must be 1..15 and SETTLE_CYC at least 1");
    end

    align_state_e     state_q, state_d;
    logic [2:0]       offset_q, offset_d;
    logic [3:0]       sweep_q, sweep_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic [7:0]       match_q, match_d;
    logic             fa_lock_q, fa_lock_d;
    logic             fa_fail_q, fa_fail_d;
    logic             busy_q, busy_d;
    logic [7:0]       aligned;
    logic             hit;

    lvds_bit_shifter u_shifter (
        .rx_slowclk (rx_slowclk),
        .rstn       (rstn),
        .data_in    (data_in),
        .offset     (offset_q),
        .aligned    (aligned),
        .data_out   (data_out)
    );

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        sweep_d  = sweep_q;
        settle_d = settle_q;
        chk_d    = chk_q;
        match_d  = match_q;
        hit      = (aligned == TRAIN_WORD);

        // PLL loss outranks a simultaneous start
        if (!rxpll_locked) begin
            state_d  = S_IDLE;
            offset_d = '0;
            sweep_d  = '0;
            settle_d = '0;
            chk_d    = '0;
            match_d  = '0;
        end else if (start) begin
            state_d  = S_SETTLE;
            offset_d = '0;
            sweep_d  = '0;
            settle_d = '0;
            chk_d    = '0;
            match_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    offset_d = '0;
                    sweep_d  = '0;
                    settle_d = '0;
                    chk_d    = '0;
                    match_d  = '0;
                end
                S_SETTLE: begin
                    if (settle_q == SET_LAST) begin
                        state_d  = S_CHECK;
                        settle_d = '0;
                        chk_d    = '0;
                        match_d  = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    chk_d   = chk_q + 1'b1;
                    match_d = hit ? match_q + 8'd1 : 8'd0;
                    if (hit && (match_q + 8'd1 == MATCH_TGT)) begin
                        state_d = S_LOCKED;
                        chk_d   = '0;
                    end else if (chk_q == CHK_LAST) begin
                        chk_d    = '0;
                        match_d  = '0;
                        settle_d = '0;
                        if (offset_q == 3'd7) begin
                            sweep_d = sweep_q + 4'd1;
                            if (sweep_q + 4'd1 == SWEEP_MAX) begin
                                state_d = S_FAIL;
                            end else begin
                                offset_d = '0;
                                state_d  = S_SETTLE;
                            end
                        end else begin
                            offset_d = offset_q + 3'd1;
                            state_d  = S_SETTLE;
                        end
                    end
                end
                S_LOCKED: ;
                S_FAIL: ;
                default: state_d = S_IDLE;
            endcase
        end

        fa_lock_d = (state_d == S_LOCKED);
        fa_fail_d = (state_d == S_FAIL);
        busy_d    = (state_d == S_SETTLE) || (state_d == S_CHECK);
    end

    always_ff @(posedge rx_slowclk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            offset_q  <= '0;
            sweep_q   <= '0;
            settle_q  <= '0;
            chk_q     <= '0;
            match_q   <= '0;
            fa_lock_q <= 1'b0;
            fa_fail_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            sweep_q   <= sweep_d;
            settle_q  <= settle_d;
            chk_q     <= chk_d;
            match_q   <= match_d;
            fa_lock_q <= fa_lock_d;
            fa_fail_q <= fa_fail_d;
            busy_q    <= busy_d;
        end
    end

    assign fa_lock    = fa_lock_q;
    assign data_valid = fa_lock_q;
    assign fa_fail    = fa_fail_q;
    assign busy       = busy_q;
    assign offset     = offset_q;

endmodule
